// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the I2C APB requester, register block and benches.
package i2c_apb_pkg;

  // Requester FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // I2C register block offsets
  localparam logic [7:0] REG_PRESC  = 8'h00;
  localparam logic [7:0] REG_CMD    = 8'h01;
  localparam logic [7:0] REG_TX     = 8'h02;
  localparam logic [7:0] REG_RX     = 8'h03;
  localparam logic [7:0] REG_ADDR   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h05;

endpackage

// File: rtl/i2c_apb_master.sv
// APB requester: one valid/ready command -> one SETUP+ACCESS transfer -> one
// response pulse. Supports back-to-back transfers and an ACCESS-phase timeout.
module i2c_apb_master
  import i2c_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 16
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [7:0]        req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  // Last ACCESS cycle index before the transfer is abandoned
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]        tmo_q, tmo_d;

  logic              in_access;
  logic              tmo_hit;
  logic              xfer_done;

  assign in_access = (state_q == ST_ACCESS);
  assign tmo_hit   = in_access && !pready_i && (tmo_q == TMO_LAST);
  assign xfer_done = in_access && (pready_i || tmo_hit);

  // Ready in IDLE, and in the finishing ACCESS cycle so a new command can
  // chain straight into SETUP without an IDLE bubble.
  assign req_ready_o = (state_q == ST_IDLE) || xfer_done;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          paddr_d   = ADDR_W'(req_addr_i);
          pwdata_d  = req_wdata_i;
          pwrite_d  = req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        tmo_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (xfer_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !pready_i;
          // Timed-out reads and all writes report zero data
          rsp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
          penable_d   = 1'b0;
          tmo_d       = '0;
          if (req_valid_i) begin
            paddr_d  = ADDR_W'(req_addr_i);
            pwdata_d = req_wdata_i;
            pwrite_d = req_write_i;
            state_d  = ST_SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        tmo_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any transfer silently
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      tmo_q       <= tmo_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
